// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Sequential instruction issuer for the 8-bit datapath.
//                Accepts 16-bit instructions over a valid/ready handshake.
//                It decodes each instruction and reads its operands from a
//                4 x 8-bit register file. It then drives op/A/B into the
//                external ALU and captures the result and flags. Finally it
//                writes the result back. Only one instruction is in flight
//                at a time: IDLE -> DECODE -> EXEC -> WB -> IDLE.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                instr_valid/ready  - instruction handshake
//                instr[15:0]        - [15:12] op, [11:10] rd, [9:8] rs,
//                                     [7:0] imm, [1:0] rt for R-type
//                alu_op/a/b         - registered ALU operands (held in EXEC)
//                alu_r, alu_flags   - ALU result and {neg, zero, ovf}
//                wb_valid/rd/data   - one-cycle writeback pulse
//                flags_q            - last committed ALU flags
//                dbg_addr/dbg_data  - combinational register file read
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
   parameter int NREG = 4,
   parameter int DW   = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [15:0]   instr,
   output logic [3:0]    alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_r,
   input  logic [2:0]    alu_flags,
   output logic          wb_valid,
   output logic [1:0]    wb_rd,
   output logic [DW-1:0] wb_data,
   output logic [2:0]    flags_q,
   input  logic [1:0]    dbg_addr,
   output logic [DW-1:0] dbg_data
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_DECODE = 2'd1;
   localparam logic [1:0] c_EXEC   = 2'd2;
   localparam logic [1:0] c_WB     = 2'd3;

   localparam logic [3:0] c_OP_NOP = 4'b0000;
   localparam logic [3:0] c_OP_LI  = 4'b1110;

   logic [1:0]    r_state;
   logic [15:0]   r_instr;
   logic [DW-1:0] r_regs [NREG];
   logic [3:0]    r_alu_op;
   logic [DW-1:0] r_alu_a;
   logic [DW-1:0] r_alu_b;
   logic          r_wb_valid;
   logic [1:0]    r_wb_rd;
   logic [DW-1:0] r_wb_data;
   logic [2:0]    r_flags_cap;
   logic [2:0]    r_flags_q;

   // Field decode of the latched instruction word
   logic [3:0]    w_op;
   logic [1:0]    w_rd;
   logic [1:0]    w_rs;
   logic [1:0]    w_rt;
   logic [DW-1:0] w_imm;
   logic          w_is_nop;
   logic          w_is_li;
   logic          w_is_rtype;
   logic          w_is_alu;

   assign w_op       = r_instr[15:12];
   assign w_rd       = r_instr[11:10];
   assign w_rs       = r_instr[9:8];
   assign w_rt       = r_instr[1:0];
   assign w_imm      = r_instr[7:0];
   assign w_is_nop   = (w_op == c_OP_NOP);
   assign w_is_li    = (w_op == c_OP_LI);
   // 1110 is LI even though op[3] is set; every other op[3]=1 code is R-type
   assign w_is_rtype = w_op[3] && !w_is_li;
   assign w_is_alu   = !w_is_nop && !w_is_li;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_instr     <= '0;
         r_alu_op    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_data   <= '0;
         r_flags_cap <= '0;
         r_flags_q   <= '0;
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_state)
            c_IDLE: begin
               if (instr_valid) begin
                  r_instr <= instr;
                  r_state <= c_DECODE;
               end
            end
            c_DECODE: begin
               // Operands are read here, after any previous writeback has
               // landed, so dependent back-to-back instructions need no bypass.
               if (w_is_alu) begin
                  r_alu_op <= w_op;
                  r_alu_a  <= r_regs[w_rs];
                  r_alu_b  <= w_is_rtype ? r_regs[w_rt] : w_imm;
               end else begin
                  r_alu_op <= '0;
                  r_alu_a  <= '0;
                  r_alu_b  <= '0;
               end
               r_state <= c_EXEC;
            end
            c_EXEC: begin
               // ALU result and flags are sampled on the edge leaving EXEC
               r_wb_valid  <= !w_is_nop;
               r_flags_cap <= alu_flags;
               if (!w_is_nop) begin
                  r_wb_rd   <= w_rd;
                  r_wb_data <= w_is_li ? w_imm : alu_r;
               end
               r_state <= c_WB;
            end
            c_WB: begin
               r_wb_valid <= 1'b0;
               if (r_wb_valid) begin
                  r_regs[r_wb_rd] <= r_wb_data;
               end
               if (w_is_alu) begin
                  r_flags_q <= r_flags_cap;
               end
               r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign instr_ready = (r_state == c_IDLE);
   assign alu_op      = r_alu_op;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign wb_valid    = r_wb_valid;
   assign wb_rd       = r_wb_rd;
   assign wb_data     = r_wb_data;
   assign flags_q     = r_flags_q;
   assign dbg_data    = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Self-checking bench for alu_issue_ctrl. Writebacks are
//                predicted into a scoreboard queue when instructions are
//                issued. They are compared when wb_valid pulses. A reference
//                register/flag model is checked through the debug port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic [3:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_r = '0;
   logic [2:0]  alu_flags = '0;
   logic        wb_valid;
   logic [1:0]  wb_rd;
   logic [7:0]  wb_data;
   logic [2:0]  flags_q;
   logic [1:0]  dbg_addr = '0;
   logic [7:0]  dbg_data;

   alu_issue_ctrl #(.NREG(4), .DW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr      (instr),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_r      (alu_r),
      .alu_flags  (alu_flags),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .flags_q    (flags_q),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [1:0] rd;
      logic [7:0] data;
   } wb_t;

   wb_t        sb_q[$];
   logic [7:0] m_reg [4];
   logic [2:0] m_flags;

   // Writeback monitor: every pulse must match the oldest prediction
   always @(negedge clk) begin : mon_wb
      wb_t e;
      if (rst_n && wb_valid) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_rd, wb_data);
         end else begin
            e = sb_q.pop_front();
            if ({wb_rd, wb_data} !== e) begin
               n_errors++;
               $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                        wb_rd, wb_data, e.rd, e.data);
            end
         end
      end
   end

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #0.5;
         n_checks++;
         if (dbg_data !== m_reg[i]) begin
            n_errors++;
            $display("FAIL %s reg%0d: got %h, required %h", tag, i, dbg_data, m_reg[i]);
         end
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (instr_ready !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL ready_timeout: got instr_ready=%b, required 1", instr_ready);
      end
   endtask

   // Issue one instruction and follow it through all four states
   task automatic issue(input logic [15:0] ins, input logic [7:0] r, input logic [2:0] f);
      logic [3:0] op, eop;
      logic [1:0] rd, rs, rt;
      logic [7:0] imm, ea, eb;
      logic       nop, li, rtype, alu;
      op    = ins[15:12];
      rd    = ins[11:10];
      rs    = ins[9:8];
      rt    = ins[1:0];
      imm   = ins[7:0];
      nop   = (op == 4'b0000);
      li    = (op == 4'b1110);
      rtype = op[3] && !li;
      alu   = !nop && !li;
      eop   = alu ? op : 4'b0000;
      ea    = alu ? m_reg[rs] : 8'h00;
      eb    = alu ? (rtype ? m_reg[rt] : imm) : 8'h00;

      wait_ready();
      instr       = ins;
      instr_valid = 1'b1;
      alu_r       = r;
      alu_flags   = f;
      if (!nop) sb_q.push_back(wb_t'({rd, (li ? imm : r)}));
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr       = 16'hFFFF;
      n_checks++;
      if (instr_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL decode_ready %h: got %b, required 0", ins, instr_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (alu_op !== eop || alu_a !== ea || alu_b !== eb) begin
         n_errors++;
         $display("FAIL exec_operands %h: got op=%b a=%h b=%h, required op=%b a=%h b=%h",
                  ins, alu_op, alu_a, alu_b, eop, ea, eb);
      end
      @(posedge clk); #1;
      n_checks++;
      if (wb_valid !== !nop) begin
         n_errors++;
         $display("FAIL wb_pulse %h: got %b, required %b", ins, wb_valid, !nop);
      end
      @(posedge clk); #1;
      if (!nop) m_reg[rd] = li ? imm : r;
      if (alu) m_flags = f;
      n_checks++;
      if (instr_ready !== 1'b1 || wb_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL back_to_idle %h: got ready=%b wb_valid=%b, required 1/0", ins, instr_ready, wb_valid);
      end
      n_checks++;
      if (flags_q !== m_flags) begin
         n_errors++;
         $display("FAIL flags_q %h: got %b, required %b", ins, flags_q, m_flags);
      end
      check_regs("after_instr");
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_flags = 3'b000;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || flags_q !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_ctrl: got ready=%b wb_valid=%b flags=%b, required 1/0/000",
                  instr_ready, wb_valid, flags_q);
      end
      n_checks++;
      if (alu_op !== 4'h0 || alu_a !== 8'h00 || alu_b !== 8'h00 || wb_rd !== 2'd0 || wb_data !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_outputs: got op=%h a=%h b=%h rd=%0d data=%h, required all 0",
                  alu_op, alu_a, alu_b, wb_rd, wb_data);
      end
      check_regs("reset");
   endtask

   task automatic test_li();
      issue(16'hE405, 8'hAA, 3'b111);   // LI r1,0x05; ALU outputs must be ignored
   endtask

   task automatic test_add();
      issue(16'hE803, 8'h55, 3'b101);   // LI r2,0x03
      issue(16'h8D02, 8'h08, 3'b000);   // ADD r3,r1,r2
   endtask

   task automatic test_subi();
      issue(16'h2505, 8'h00, 3'b010);   // SUBI r1,r1,0x05 -> zero flag
   endtask

   task automatic test_nop();
      issue(16'h0000, 8'h77, 3'b101);
   endtask

   task automatic test_hazard();
      issue(16'hFA03, 8'hC5, 3'b100);   // op 1111 R-type, rd=rs=r2, rt=r3
      issue(16'h7A01, 8'hC6, 3'b001);   // op 0111 I-type reads the new r2
   endtask

   task automatic test_back_to_back();
      logic [15:0] list [3];
      int          acc_cyc [3];
      int          idx;
      logic        acc;
      list[0] = 16'hE011;
      list[1] = 16'hE422;
      list[2] = 16'hE833;
      idx = 0;
      wait_ready();
      instr       = list[0];
      instr_valid = 1'b1;
      for (int c = 0; c < 40 && idx < 3; c++) begin
         acc = instr_ready && instr_valid;
         if (acc) begin
            acc_cyc[idx] = cyc;
            sb_q.push_back(wb_t'({list[idx][11:10], list[idx][7:0]}));
            m_reg[list[idx][11:10]] = list[idx][7:0];
            idx++;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (idx < 3) instr = list[idx];
            else instr_valid = 1'b0;
         end
         @(negedge clk);
      end
      instr_valid = 1'b0;
      n_checks++;
      if (idx != 3) begin
         n_errors++;
         $display("FAIL stream_accepts: got %0d, required 3", idx);
      end else begin
         n_checks++;
         if (acc_cyc[1] - acc_cyc[0] != 4 || acc_cyc[2] - acc_cyc[1] != 4) begin
            n_errors++;
            $display("FAIL stream_spacing: got %0d,%0d, required 4,4",
                     acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
         end
      end
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL stream_pending: got %0d writebacks outstanding, required 0", sb_q.size());
      end
      check_regs("stream");
   endtask

   task automatic test_reset_mid();
      wait_ready();
      instr       = 16'h8D02;           // ADD r3,r1,r2
      instr_valid = 1'b1;
      alu_r       = 8'h99;
      alu_flags   = 3'b100;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;               // now in EXEC
      n_checks++;
      if (alu_op !== 4'b1000) begin
         n_errors++;
         $display("FAIL mid_exec_op: got %b, required 1000", alu_op);
      end
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_flags = 3'b000;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (instr_ready !== 1'b1 || flags_q !== 3'b000) begin
         n_errors++;
         $display("FAIL mid_reset_state: got ready=%b flags=%b, required 1/000", instr_ready, flags_q);
      end
      repeat (4) begin
         @(posedge clk); #1;
         n_checks++;
         if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset_idle: got wb_valid=%b ready=%b, required 0/1", wb_valid, instr_ready);
         end
      end
      check_regs("mid_reset");
   endtask

   initial begin
      test_reset();
      test_li();
      test_add();
      test_subi();
      test_nop();
      test_hazard();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
